// File: rtl/polar_frame_error_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | polar_frame_error_counter: FIFO-backed tx/rx frame comparator with         |
// | saturating frame, bit-error and frame-error counters.                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module polar_frame_error_counter #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [N-1:0]               tx_bits,
  input  logic                       rx_valid,
  input  logic [N-1:0]               rx_bits,
  input  logic                       clear,
  output logic                       result_valid,
  output logic [$clog2(N+1)-1:0]     frame_bit_err,
  output logic [CNT_W-1:0]           frames,
  output logic [CNT_W-1:0]           bit_errors,
  output logic [CNT_W-1:0]           frame_errors,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_ERR_W  = $clog2(N + 1);
  localparam int c_FILL_W = $clog2(DEPTH + 1);
  localparam int c_SUM_W  = ((CNT_W > c_ERR_W) ? CNT_W : c_ERR_W) + 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [N-1:0]       r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [N-1:0]       r_diff;
  logic               r_v1;

  logic               w_flush;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [c_ERR_W-1:0] w_err;
  logic [c_SUM_W-1:0] w_bit_sum;
  logic [CNT_W-1:0]   w_frames_nxt;
  logic [CNT_W-1:0]   w_bit_nxt;
  logic [CNT_W-1:0]   w_ferr_nxt;

  assign w_flush  = rst | clear;
  assign tx_ready = (fill != c_FILL_W'(DEPTH));
  assign w_empty  = (fill == '0);
  // Full/empty are judged on registered fill only, so a same-cycle pop never frees a slot for a push.
  assign w_push   = tx_valid & tx_ready & ~w_flush;
  assign w_pop    = rx_valid & ~w_empty & ~w_flush;

  always_comb begin
    w_err = '0;
    for (int i = 0; i < N; i++) begin
      w_err = w_err + c_ERR_W'(r_diff[i]);
    end
  end

  assign w_bit_sum    = c_SUM_W'(bit_errors) + c_SUM_W'(w_err);
  assign w_bit_nxt    = (w_bit_sum > c_SUM_W'(c_CNT_MAX)) ? c_CNT_MAX : w_bit_sum[CNT_W-1:0];
  assign w_frames_nxt = (frames == c_CNT_MAX) ? frames : frames + CNT_W'(1);
  assign w_ferr_nxt   = ((w_err == '0) || (frame_errors == c_CNT_MAX)) ?
                        frame_errors : frame_errors + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      fill          <= '0;
      r_diff        <= '0;
      r_v1          <= 1'b0;
      result_valid  <= 1'b0;
      frame_bit_err <= '0;
      frames        <= '0;
      bit_errors    <= '0;
      frame_errors  <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        r_diff   <= r_mem[r_rd_ptr] ^ rx_bits;
      end
      if (w_push && !w_pop) begin
        fill <= fill + c_FILL_W'(1);
      end else if (!w_push && w_pop) begin
        fill <= fill - c_FILL_W'(1);
      end
      if (tx_valid && !tx_ready) begin
        overflow <= 1'b1;
      end
      if (rx_valid && w_empty) begin
        underflow <= 1'b1;
      end
      r_v1         <= w_pop;
      result_valid <= r_v1;
      if (r_v1) begin
        frame_bit_err <= w_err;
        frames        <= w_frames_nxt;
        bit_errors    <= w_bit_nxt;
        frame_errors  <= w_ferr_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_polar_frame_error_counter.sv
`default_nettype none
// Randomized bench: two counters (wide and 4-bit) share stimulus and are checked
// against a transaction-level queue model with saturating arithmetic.
module tb_polar_frame_error_counter;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW_A  = 32;
  localparam int CW_B  = 4;

  logic clk = 1'b0;
  logic rst, clear, tx_valid, rx_valid;
  logic [N-1:0] tx_bits, rx_bits;

  logic        a_tx_ready, a_rv, a_ovf, a_unf;
  logic [5:0]  a_fbe;
  logic [CW_A-1:0] a_frames, a_bits, a_ferr;
  logic [2:0]  a_fill;
  logic        b_tx_ready, b_rv, b_ovf, b_unf;
  logic [5:0]  b_fbe;
  logic [CW_B-1:0] b_frames, b_bits, b_ferr;
  logic [2:0]  b_fill;

  always #5 clk = ~clk;

  polar_frame_error_counter #(.N(N), .DEPTH(DEPTH), .CNT_W(CW_A)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(a_tx_ready), .tx_bits(tx_bits),
    .rx_valid(rx_valid), .rx_bits(rx_bits), .clear(clear), .result_valid(a_rv),
    .frame_bit_err(a_fbe), .frames(a_frames), .bit_errors(a_bits), .frame_errors(a_ferr),
    .fill(a_fill), .overflow(a_ovf), .underflow(a_unf));

  polar_frame_error_counter #(.N(N), .DEPTH(DEPTH), .CNT_W(CW_B)) dut_sat (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(b_tx_ready), .tx_bits(tx_bits),
    .rx_valid(rx_valid), .rx_bits(rx_bits), .clear(clear), .result_valid(b_rv),
    .frame_bit_err(b_fbe), .frames(b_frames), .bit_errors(b_bits), .frame_errors(b_ferr),
    .fill(b_fill), .overflow(b_ovf), .underflow(b_unf));

  typedef struct { int due; int err; } res_t;

  logic [N-1:0] q[$];
  res_t         pend[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  longint       m_frames_a, m_bits_a, m_ferr_a, m_frames_b, m_bits_b, m_ferr_b;
  int           m_fbe;
  bit           m_rv, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic longint sat_add(input longint a, input longint b, input longint mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  task automatic model_flush();
    q.delete();
    pend.delete();
    m_frames_a = 0; m_bits_a = 0; m_ferr_a = 0;
    m_frames_b = 0; m_bits_b = 0; m_ferr_b = 0;
    m_fbe = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic step(input bit r, input bit c, input bit tv, input logic [N-1:0] tb,
                      input bit rv, input logic [N-1:0] rb);
    bit full, empty;
    rst = r; clear = c; tx_valid = tv; tx_bits = tb; rx_valid = rv; rx_bits = rb;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (r || c) begin
      model_flush();
    end else begin
      if (tv && full) m_ovf = 1;
      if (rv && empty) m_unf = 1;
      if (rv && !empty) begin
        pend.push_back('{due: cyc + 2, err: $countones(q[0] ^ rb)});
        void'(q.pop_front());
      end
      if (tv && !full) q.push_back(tb);
    end
    @(posedge clk);
    cyc++;
    m_rv = 0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      m_rv  = 1;
      m_fbe = pend[0].err;
      m_frames_a = sat_add(m_frames_a, 1, (64'd1 << CW_A) - 1);
      m_bits_a   = sat_add(m_bits_a, m_fbe, (64'd1 << CW_A) - 1);
      m_ferr_a   = sat_add(m_ferr_a, (m_fbe != 0) ? 1 : 0, (64'd1 << CW_A) - 1);
      m_frames_b = sat_add(m_frames_b, 1, (64'd1 << CW_B) - 1);
      m_bits_b   = sat_add(m_bits_b, m_fbe, (64'd1 << CW_B) - 1);
      m_ferr_b   = sat_add(m_ferr_b, (m_fbe != 0) ? 1 : 0, (64'd1 << CW_B) - 1);
      void'(pend.pop_front());
    end
    #1;
    chk("tx_ready",      a_tx_ready, q.size() != DEPTH);
    chk("fill",          a_fill, q.size());
    chk("overflow",      a_ovf, m_ovf);
    chk("underflow",     a_unf, m_unf);
    chk("result_valid",  a_rv, m_rv);
    chk("frame_bit_err", a_fbe, m_fbe);
    chk("frames",        a_frames, m_frames_a);
    chk("bit_errors",    a_bits, m_bits_a);
    chk("frame_errors",  a_ferr, m_ferr_a);
    chk("sat_fill",      b_fill, q.size());
    chk("sat_result_valid", b_rv, m_rv);
    chk("sat_frames",    b_frames, m_frames_b);
    chk("sat_bit_errors", b_bits, m_bits_b);
    chk("sat_frame_errors", b_ferr, m_ferr_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
  endtask

  task automatic do_clear();
    step(0, 1, 0, '0, 0, '0);
  endtask

  initial begin
    logic [N-1:0] d, m;
    rst = 1; clear = 0; tx_valid = 0; rx_valid = 0; tx_bits = '0; rx_bits = '0;
    model_flush();
    step(1, 0, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0);

    // matching frame
    step(0, 0, 1, 32'hF0F0F0F0, 0, '0);
    idle(2);
    step(0, 0, 0, '0, 1, 32'hF0F0F0F0);
    idle(2);

    // four bit errors
    do_clear();
    step(0, 0, 1, 32'h0000000F, 0, '0);
    idle(1);
    step(0, 0, 0, '0, 1, 32'h00000000);
    idle(2);

    // fill to full, drop the fifth push, drain
    do_clear();
    for (int i = 0; i < 5; i++) step(0, 0, 1, $urandom, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, q[0]);
    idle(2);

    // underflow, then push and pop together into empty
    do_clear();
    step(0, 0, 0, '0, 1, $urandom);
    step(0, 0, 1, $urandom, 1, $urandom);
    idle(2);

    // sixteen single-error frames: 4-bit counters stick at 15
    do_clear();
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, $urandom, 0, '0);
      d = q[0];
      d[$urandom_range(N - 1)] ^= 1'b1;
      step(0, 0, 0, '0, 1, d);
    end
    idle(2);

    // clear and rst while a result is in flight
    do_clear();
    step(0, 0, 1, $urandom, 0, '0);
    idle(1);
    step(0, 0, 0, '0, 1, ~q[0]);
    do_clear();
    idle(2);
    step(0, 0, 1, $urandom, 0, '0);
    step(0, 0, 1, $urandom, 1, q[0] ^ 32'h1);
    step(1, 0, 0, '0, 0, '0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit tv, rv, r, c;
      r  = ($urandom_range(299) == 0);
      c  = ($urandom_range(99) == 0);
      tv = $urandom_range(1);
      rv = ($urandom_range(2) != 0);
      d  = $urandom;
      if (q.size() > 0 && $urandom_range(3) != 0) begin
        m = ($urandom_range(1) == 0) ? '0 : ($urandom & $urandom & $urandom);
        rx_bits = q[0] ^ m;
      end else begin
        rx_bits = $urandom;
      end
      step(r, c, tv, d, rv, rx_bits);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
